// File: rtl/spim_boot_pkg.sv
// spim_boot_pkg
//   Shared AHB-lite definitions and sequencer state encoding for spim_boot.
//   Contents: state_e (sequencer states), HTRANS/HRESP/HSIZE constants,
//   the SPI master control-register address, and a helper that flags the
//   states in which an AHB address phase is being presented.
package spim_boot_pkg;

   typedef enum logic [3:0] {
      ST_WAIT_INIT = 4'd0,
      ST_CFG_A     = 4'd1,
      ST_CFG_D     = 4'd2,
      ST_RD_A      = 4'd3,
      ST_RD_D      = 4'd4,
      ST_WR_A      = 4'd5,
      ST_WR_D      = 4'd6,
      ST_DONE      = 4'd7,
      ST_ERR       = 4'd8
   } state_e;

   localparam logic [1:0]  HTRANS_IDLE    = 2'b00;
   localparam logic [1:0]  HTRANS_NONSEQ  = 2'b10;
   localparam logic [1:0]  HRESP_OKAY     = 2'b00;
   localparam logic [2:0]  HSIZE_WORD     = 3'b010;
   localparam logic [31:0] SPIM_CTRL_ADDR = 32'h0800_000C;

   function automatic logic is_addr_state(input state_e s);
      return (s == ST_CFG_A) || (s == ST_RD_A) || (s == ST_WR_A);
   endfunction

endpackage

// File: rtl/spim_boot.sv
// spim_boot
//   Boot sequencer: waits for the SPI flash master to finish power-up,
//   programs its control register, then copies WORD_CNT words from the flash
//   read window to SRAM over a single-master, non-pipelined AHB-lite port,
//   accumulating a 32-bit checksum of every word read. The CPU is held in
//   reset until the copy completes.
// Ports
//   HCLK, HRST          clock, synchronous active-high reset
//   Initialized         SPI master power-up done
//   M_H*                AHB-lite master interface
//   CPU_RST             1 until the copy has completed
//   BOOT_DONE/BOOT_ERR  terminal status (registered)
//   CHECKSUM            modulo-2^32 sum of all words read
module spim_boot
   import spim_boot_pkg::*;
#(
   parameter logic [25:0] CTRL_WORD = 26'h0_0B_0004,
   parameter logic [31:0] SRC_BASE  = 32'h0000_0000,
   parameter logic [31:0] DST_BASE  = 32'h2000_0000,
   parameter logic [15:0] WORD_CNT  = 16'd256,
   parameter logic [31:0] INIT_TMO  = 32'h0003_0D40
) (
   input  logic        HCLK,
   input  logic        HRST,
   input  logic        Initialized,
   output logic [1:0]  M_HTRANS,
   output logic [31:0] M_HADDR,
   output logic        M_HWRITE,
   output logic [2:0]  M_HSIZE,
   output logic [31:0] M_HWDATA,
   input  logic [31:0] M_HRDATA,
   input  logic        M_HREADY,
   input  logic [1:0]  M_HRESP,
   output logic        CPU_RST,
   output logic        BOOT_DONE,
   output logic        BOOT_ERR,
   output logic [31:0] CHECKSUM
);

   state_e      state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic [15:0] idx_q, idx_d;
   logic [31:0] data_q, data_d;
   logic [31:0] csum_q, csum_d;
   logic        cpu_rst_q, done_q, err_q;

   logic        data_ok;
   logic        data_bad;
   logic [31:0] byte_off;

   assign data_ok  = M_HREADY && (M_HRESP == HRESP_OKAY);
   assign data_bad = M_HREADY && (M_HRESP != HRESP_OKAY);
   assign byte_off = {14'd0, idx_q, 2'b00};

   always_ff @(posedge HCLK) begin
      if (HRST) begin
         state_q   <= ST_WAIT_INIT;
         cnt_q     <= 32'd0;
         idx_q     <= 16'd0;
         data_q    <= 32'd0;
         csum_q    <= 32'd0;
         cpu_rst_q <= 1'b1;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         data_q    <= data_d;
         csum_q    <= csum_d;
         // Status flops follow the next state so they line up with state_q.
         cpu_rst_q <= (state_d != ST_DONE);
         done_q    <= (state_d == ST_DONE);
         err_q     <= (state_d == ST_ERR);
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      data_d  = data_q;
      csum_d  = csum_q;
      case (state_q)
         ST_WAIT_INIT: begin
            cnt_d = cnt_q + 32'd1;
            if (Initialized)              state_d = ST_CFG_A;
            else if (cnt_q == INIT_TMO)   state_d = ST_ERR;
         end
         ST_CFG_A: if (M_HREADY) state_d = ST_CFG_D;
         ST_CFG_D: begin
            if (data_bad)     state_d = ST_ERR;
            else if (data_ok) state_d = (WORD_CNT == 16'd0) ? ST_DONE : ST_RD_A;
         end
         ST_RD_A: if (M_HREADY) state_d = ST_RD_D;
         ST_RD_D: begin
            if (data_bad) begin
               state_d = ST_ERR;
            end else if (data_ok) begin
               data_d  = M_HRDATA;
               csum_d  = csum_q + M_HRDATA;
               state_d = ST_WR_A;
            end
         end
         ST_WR_A: if (M_HREADY) state_d = ST_WR_D;
         ST_WR_D: begin
            if (data_bad) begin
               state_d = ST_ERR;
            end else if (data_ok) begin
               idx_d = idx_q + 16'd1;
               // 17-bit compare so idx+1 cannot wrap at WORD_CNT=16'hFFFF.
               state_d = (({1'b0, idx_q} + 17'd1) < {1'b0, WORD_CNT}) ? ST_RD_A : ST_DONE;
            end
         end
         ST_DONE: state_d = ST_DONE;
         ST_ERR:  state_d = ST_ERR;
         default: state_d = ST_ERR;
      endcase
   end

   // Bus outputs decode the current state only. Each address/data state pair
   // drives the same address and control, so everything stays put while the
   // slave stretches a phase with HREADY low.
   always_comb begin
      M_HTRANS = is_addr_state(state_q) ? HTRANS_NONSEQ : HTRANS_IDLE;
      M_HSIZE  = HSIZE_WORD;
      M_HADDR  = 32'd0;
      M_HWRITE = 1'b0;
      M_HWDATA = 32'd0;
      case (state_q)
         ST_CFG_A: begin
            M_HADDR  = SPIM_CTRL_ADDR;
            M_HWRITE = 1'b1;
         end
         ST_CFG_D: begin
            M_HADDR  = SPIM_CTRL_ADDR;
            M_HWRITE = 1'b1;
            M_HWDATA = {6'b0, CTRL_WORD};
         end
         ST_RD_A, ST_RD_D: M_HADDR = SRC_BASE + byte_off;
         ST_WR_A: begin
            M_HADDR  = DST_BASE + byte_off;
            M_HWRITE = 1'b1;
         end
         ST_WR_D: begin
            M_HADDR  = DST_BASE + byte_off;
            M_HWRITE = 1'b1;
            M_HWDATA = data_q;
         end
         default: ;
      endcase
   end

   assign CPU_RST   = cpu_rst_q;
   assign BOOT_DONE = done_q;
   assign BOOT_ERR  = err_q;
   assign CHECKSUM  = csum_q;

endmodule

// File: tb/tb_spim_boot.sv
// tb_spim_boot
//   Scoreboard bench for spim_boot. dut_a (WORD_CNT=4, INIT_TMO=100) runs
//   the copy, wait-state, timeout, bus-error and mid-copy reset scenarios
//   against a negedge-driven slave model; dut_b (WORD_CNT=0) checks the
//   control-write-only path. Expected bus transfers are queued by the
//   stimulus and popped by the slave monitors as each data phase completes.
`timescale 1ns/1ps
module tb_spim_boot;
   import spim_boot_pkg::*;

   localparam logic [31:0] DST      = 32'h2000_0000;
   localparam logic [31:0] CTRL_EXP = 32'h000B_0004;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
   } txn_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // dut_a bus
   logic        a_rst = 1'b1, a_init = 1'b0;
   logic [1:0]  a_htrans;
   logic [31:0] a_haddr, a_hwdata, a_hrdata = 32'd0, a_checksum;
   logic        a_hwrite, a_hready = 1'b1;
   logic [2:0]  a_hsize;
   logic [1:0]  a_hresp = 2'b00;
   logic        a_cpu_rst, a_boot_done, a_boot_err;

   // dut_b bus
   logic        b_rst = 1'b1, b_init = 1'b1;
   logic [1:0]  b_htrans;
   logic [31:0] b_haddr, b_hwdata, b_checksum;
   logic        b_hwrite;
   logic [2:0]  b_hsize;
   logic        b_cpu_rst, b_boot_done, b_boot_err;

   spim_boot #(.WORD_CNT(16'd4), .INIT_TMO(32'd100)) dut_a (
      .HCLK(clk), .HRST(a_rst), .Initialized(a_init),
      .M_HTRANS(a_htrans), .M_HADDR(a_haddr), .M_HWRITE(a_hwrite),
      .M_HSIZE(a_hsize), .M_HWDATA(a_hwdata), .M_HRDATA(a_hrdata),
      .M_HREADY(a_hready), .M_HRESP(a_hresp), .CPU_RST(a_cpu_rst),
      .BOOT_DONE(a_boot_done), .BOOT_ERR(a_boot_err), .CHECKSUM(a_checksum));

   spim_boot #(.WORD_CNT(16'd0)) dut_b (
      .HCLK(clk), .HRST(b_rst), .Initialized(b_init),
      .M_HTRANS(b_htrans), .M_HADDR(b_haddr), .M_HWRITE(b_hwrite),
      .M_HSIZE(b_hsize), .M_HWDATA(b_hwdata), .M_HRDATA(32'd0),
      .M_HREADY(1'b1), .M_HRESP(2'b00), .CPU_RST(b_cpu_rst),
      .BOOT_DONE(b_boot_done), .BOOT_ERR(b_boot_err), .CHECKSUM(b_checksum));

   int   n_cmp = 0, n_bad = 0;
   txn_t qa[$], qb[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   task automatic push_a(input logic wr, input logic [31:0] addr, input logic [31:0] data);
      txn_t t;
      t.wr = wr; t.addr = addr; t.data = data;
      qa.push_back(t);
   endtask

   // Control write, then read word i from 4*i and write it to DST+4*i.
   task automatic push_full();
      push_a(1'b1, SPIM_CTRL_ADDR, CTRL_EXP);
      for (int i = 0; i < 4; i++) begin
         push_a(1'b0, 32'(4 * i), 32'd0);
         push_a(1'b1, DST + 32'(4 * i), 32'(i + 1));
      end
   endtask

   // ---------------- dut_a slave model + monitor ----------------
   int          wait_n = 0, waits = 0, rd_cnt = 0, nonseq_a = 0;
   bit          err_en = 1'b0, in_data = 1'b0, acc = 1'b0, fin = 1'b0, first = 1'b0;
   logic [31:0] d_addr = 32'd0, d_wdata = 32'd0;
   logic        d_write = 1'b0;
   logic [31:0] rom [4] = '{32'd1, 32'd2, 32'd3, 32'd4};

   always @(negedge clk) begin
      txn_t t;
      a_hresp = 2'b00;
      if (a_rst) begin
         in_data = 0; acc = 0; fin = 0; a_hready = 1'b1;
      end else begin
         if (fin) begin in_data = 0; fin = 0; end
         if (acc) begin in_data = 1; acc = 0; waits = wait_n; first = 1; end
         if (in_data) begin
            check("htrans_idle_in_data", {30'd0, a_htrans}, {30'd0, HTRANS_IDLE});
            check("haddr_hold", a_haddr, d_addr);
            if (d_write) begin
               if (first) d_wdata = a_hwdata;
               else       check("hwdata_hold", a_hwdata, d_wdata);
            end
            first = 0;
            if (waits > 0) begin
               a_hready = 1'b0;
               waits--;
            end else begin
               a_hready = 1'b1;
               fin = 1;
               if (!d_write) begin
                  rd_cnt++;
                  a_hrdata = rom[d_addr[3:2]];
                  if (err_en && rd_cnt == 2) a_hresp = 2'b01;
               end
               if (qa.size() == 0) begin
                  n_cmp++; n_bad++;
                  $display("FAIL unexpected_txn: got addr %h wr %0d expected none", d_addr, d_write);
               end else begin
                  t = qa.pop_front();
                  check("txn_write", {31'd0, d_write}, {31'd0, t.wr});
                  check("txn_addr", d_addr, t.addr);
                  if (t.wr) check("txn_wdata", a_hwdata, t.data);
               end
            end
         end else begin
            a_hready = 1'b1;
            if (a_htrans == HTRANS_NONSEQ) begin
               acc = 1; nonseq_a++;
               d_addr = a_haddr; d_write = a_hwrite;
               check("hsize", {29'd0, a_hsize}, 32'd2);
            end
         end
      end
   end

   // ---------------- dut_b monitor (always-ready slave) ----------------
   int          nonseq_b = 0;
   bit          b_in = 1'b0;
   logic [31:0] bd_addr = 32'd0;
   logic        bd_wr = 1'b0;

   always @(negedge clk) begin
      txn_t t;
      if (!b_rst) begin
         if (b_in) begin
            b_in = 0;
            if (qb.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL b_unexpected_txn: got addr %h expected none", bd_addr);
            end else begin
               t = qb.pop_front();
               check("b_txn_write", {31'd0, bd_wr}, {31'd0, t.wr});
               check("b_txn_addr", bd_addr, t.addr);
               check("b_txn_wdata", b_hwdata, t.data);
            end
         end
         if (b_htrans == HTRANS_NONSEQ) begin
            b_in = 1; nonseq_b++;
            bd_addr = b_haddr; bd_wr = b_hwrite;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic wait_end(input string name, input int bound, output int cycles);
      cycles = 0;
      while (!(a_boot_done || a_boot_err) && cycles < bound) begin
         @(posedge clk); #2;
         cycles++;
      end
      if (!(a_boot_done || a_boot_err)) begin
         n_cmp++; n_bad++;
         $display("FAIL %s_timeout: got no terminal state expected one within %0d cycles", name, bound);
      end
   endtask

   task automatic release_and_init();
      @(posedge clk); #2;
      a_rst = 1'b0;
      repeat (10) @(posedge clk);
      #2 a_init = 1'b1;
   endtask

   task automatic reset_a();
      @(posedge clk); #2;
      a_rst = 1'b1; a_init = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      qa.delete();
   endtask

   task automatic run_copy(input string name, input int wn);
      int cyc;
      wait_n = wn; nonseq_a = 0;
      push_full();
      release_and_init();
      wait_end(name, 2000, cyc);
      check({name, "_done"}, {31'd0, a_boot_done}, 32'd1);
      check({name, "_err"}, {31'd0, a_boot_err}, 32'd0);
      check({name, "_checksum"}, a_checksum, 32'd10);
      check({name, "_cpu_rst"}, {31'd0, a_cpu_rst}, 32'd0);
      check({name, "_nonseq"}, 32'(nonseq_a), 32'd9);
      check({name, "_queue_empty"}, 32'(qa.size()), 32'd0);
      reset_a();
   endtask

   initial begin
      txn_t tb;
      int   cyc, snap;
      repeat (3) @(posedge clk);
      #2;
      check("rst_cpu_rst", {31'd0, a_cpu_rst}, 32'd1);
      check("rst_boot_done", {31'd0, a_boot_done}, 32'd0);
      check("rst_boot_err", {31'd0, a_boot_err}, 32'd0);
      check("rst_htrans", {30'd0, a_htrans}, 32'd0);
      check("rst_haddr", a_haddr, 32'd0);
      check("rst_hwrite", {31'd0, a_hwrite}, 32'd0);
      check("rst_hsize", {29'd0, a_hsize}, 32'd2);
      check("rst_hwdata", a_hwdata, 32'd0);
      check("rst_checksum", a_checksum, 32'd0);

      // dut_b: WORD_CNT=0 -> one control write then DONE
      tb.wr = 1'b1; tb.addr = SPIM_CTRL_ADDR; tb.data = CTRL_EXP;
      qb.push_back(tb);
      b_rst = 1'b0;

      run_copy("zero_wait", 0);
      run_copy("three_wait", 3);

      // Initialized never rises: ERR on the edge where counter==100
      nonseq_a = 0;
      @(posedge clk); #2;
      a_rst = 1'b0;
      cyc = 0;
      while (!a_boot_err && cyc < 300) begin
         @(posedge clk); #2;
         cyc++;
      end
      check("tmo_cycles", 32'(cyc), 32'd101);
      check("tmo_boot_err", {31'd0, a_boot_err}, 32'd1);
      check("tmo_nonseq", 32'(nonseq_a), 32'd0);
      check("tmo_cpu_rst", {31'd0, a_cpu_rst}, 32'd1);
      check("tmo_boot_done", {31'd0, a_boot_done}, 32'd0);
      reset_a();

      // HRESP error on the second read
      wait_n = 0; err_en = 1'b1; rd_cnt = 0; nonseq_a = 0;
      push_a(1'b1, SPIM_CTRL_ADDR, CTRL_EXP);
      push_a(1'b0, 32'd0, 32'd0);
      push_a(1'b1, DST, 32'd1);
      push_a(1'b0, 32'd4, 32'd0);
      release_and_init();
      wait_end("bus_err", 2000, cyc);
      check("berr_boot_err", {31'd0, a_boot_err}, 32'd1);
      check("berr_boot_done", {31'd0, a_boot_done}, 32'd0);
      check("berr_checksum", a_checksum, 32'd1);
      check("berr_cpu_rst", {31'd0, a_cpu_rst}, 32'd1);
      snap = nonseq_a;
      repeat (20) @(posedge clk);
      #2;
      check("berr_no_more_xfers", 32'(nonseq_a), 32'(snap));
      check("berr_queue_empty", 32'(qa.size()), 32'd0);
      err_en = 1'b0;
      reset_a();

      // Reset pulsed during the third SRAM write, then full rerun
      push_full();
      release_and_init();
      cyc = 0;
      while (!(a_htrans == HTRANS_NONSEQ && a_hwrite && a_haddr == DST + 32'd8) && cyc < 2000) begin
         @(posedge clk); #2;
         cyc++;
      end
      check("mid_rst_reached_wr3", a_haddr, DST + 32'd8);
      a_rst = 1'b1;
      qa.delete();
      @(posedge clk); #2;
      check("mid_rst_checksum", a_checksum, 32'd0);
      check("mid_rst_htrans", {30'd0, a_htrans}, 32'd0);
      check("mid_rst_cpu_rst", {31'd0, a_cpu_rst}, 32'd1);
      @(posedge clk); #2;
      nonseq_a = 0;
      push_full();
      a_rst = 1'b0;
      wait_end("rerun", 2000, cyc);
      check("rerun_done", {31'd0, a_boot_done}, 32'd1);
      check("rerun_checksum", a_checksum, 32'd10);
      check("rerun_cpu_rst", {31'd0, a_cpu_rst}, 32'd0);
      check("rerun_nonseq", 32'(nonseq_a), 32'd9);
      check("rerun_queue_empty", 32'(qa.size()), 32'd0);

      // dut_b final state
      check("b_boot_done", {31'd0, b_boot_done}, 32'd1);
      check("b_boot_err", {31'd0, b_boot_err}, 32'd0);
      check("b_checksum", b_checksum, 32'd0);
      check("b_cpu_rst", {31'd0, b_cpu_rst}, 32'd0);
      check("b_nonseq", 32'(nonseq_b), 32'd1);
      check("b_queue_empty", 32'(qb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got no end of test expected end within 400000 ns");
      $fatal(1, "watchdog expired");
   end

endmodule
